// File: rtl/spi_mem_pkg.sv
// Shared types for the SPI memory slave: FSM states, command codes, width helper.
// Latency: n/a (types only). Backpressure: n/a.
// Optional feature macro used by the slave: SPI_MEM_AUTOINC_EN.
package spi_mem_pkg;

    localparam int CMD_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        RX,
        RD_WAIT,
        TX,
        DONE
    } state_t;

    typedef enum logic [CMD_W-1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_mem_ram.sv
// Single-port-write / registered-read RAM; out-of-range writes dropped, reads return zero.
// Latency: read data valid 1 clk after address. Backpressure: none, accepts every cycle.
// Contents are not reset; only the read register is.
module spi_mem_ram #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_dat
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);

    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic              wr_ok;
    logic              rd_ok;

    assign wr_ok = ({1'b0, wr_addr} < DEPTH_L);
    assign rd_ok = ({1'b0, rd_addr} < DEPTH_L);

    always_ff @(posedge clk) begin
        if (wr_en && wr_ok) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_dat <= '0;
        end else begin
            rd_dat <= rd_ok ? mem[rd_addr] : '0;
        end
    end

endmodule

// File: rtl/spi_mem_slave.sv
// SPI slave fronting a RAM: 2-bit command + W-bit payload frames, read data shifted out MSB first.
// Latency: read data starts on MISO 1 clk after the last payload bit. Backpressure: none; SS_n high mid-frame aborts.
// Define SPI_MEM_AUTOINC_EN to post-increment wr_addr/rd_addr after each completed data frame.
module spi_mem_slave
    import spi_mem_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic MOSI,
    input  logic SS_n,
    output logic MISO,
    output logic frame_err
);

    localparam int W     = max_int(ADDR_W, DATA_W);
    // W >= DATA_W, so one counter covers both the payload and the TX bit count.
    localparam int CNT_W = $clog2(W + 1);

    state_t            state;
    cmd_t              cmd;
    logic [W-2:0]      sh;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rd_dat;
    logic [W-1:0]      pay_nxt;
    logic              last_bit;
    logic              ram_we;

`ifdef SPI_MEM_AUTOINC_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return (a >= LAST_ADDR) ? '0 : a + 1'b1;
    endfunction
`endif

    assign pay_nxt  = {sh, MOSI};
    assign last_bit = (state == RX) && !SS_n && (cnt == CNT_W'(W - 1));
    assign ram_we   = last_bit && (cmd == CMD_WR_DATA);

    spi_mem_ram #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (ram_we),
        .wr_addr (wr_addr),
        .wr_dat  (pay_nxt[DATA_W-1:0]),
        .rd_addr (rd_addr),
        .rd_dat  (rd_dat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd       <= CMD_WR_ADDR;
            sh        <= '0;
            cnt       <= '0;
            wr_addr   <= '0;
            rd_addr   <= '0;
            tx_sh     <= '0;
            MISO      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            // Deselect mid-frame discards everything captured so far.
            if (SS_n && (state inside {CMD, RX, RD_WAIT, TX})) begin
                state     <= IDLE;
                cnt       <= '0;
                MISO      <= 1'b0;
                frame_err <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        MISO <= 1'b0;
                        cnt  <= '0;
                        if (!SS_n) state <= CMD;
                    end
                    CMD: begin
                        cmd <= cmd_t'({cmd[0], MOSI});
                        if (cnt == CNT_W'(CMD_W - 1)) begin
                            cnt   <= '0;
                            state <= RX;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    RX: begin
                        sh <= pay_nxt[W-2:0];
                        if (last_bit) begin
                            cnt <= '0;
                            case (cmd)
                                CMD_WR_ADDR: wr_addr <= pay_nxt[ADDR_W-1:0];
                                CMD_WR_DATA: begin
`ifdef SPI_MEM_AUTOINC_EN
                                    wr_addr <= addr_inc(wr_addr);
`endif
                                end
                                CMD_RD_ADDR: rd_addr <= pay_nxt[ADDR_W-1:0];
                                default: ;
                            endcase
                            state <= (cmd == CMD_RD_DATA) ? RD_WAIT : DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    RD_WAIT: begin
                        MISO  <= rd_dat[DATA_W-1];
                        tx_sh <= rd_dat << 1;
                        cnt   <= CNT_W'(1);
                        state <= TX;
                    end
                    TX: begin
                        if (cnt == CNT_W'(DATA_W)) begin
                            MISO  <= 1'b0;
                            cnt   <= '0;
                            state <= DONE;
`ifdef SPI_MEM_AUTOINC_EN
                            rd_addr <= addr_inc(rd_addr);
`endif
                        end else begin
                            MISO  <= tx_sh[DATA_W-1];
                            tx_sh <= tx_sh << 1;
                            cnt   <= cnt + 1'b1;
                        end
                    end
                    DONE: begin
                        MISO <= 1'b0;
                        if (SS_n) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_mem_slave.sv
// Randomized frame stimulus against a frame-level memory model; two DUTs (depth 256 and 200) share the SPI bus.
// Expected outputs per cycle are derived from the frame layout and the model memories.
module tb_spi_mem_slave;

    localparam int W = 8;

    logic clk;
    logic rst_n;
    logic MOSI;
    logic SS_n;
    logic miso_a, miso_b, ferr_a, ferr_b;

    spi_mem_slave #(.ADDR_W(8), .DATA_W(8), .MEM_DEPTH(256)) dut_a (
        .clk(clk), .rst_n(rst_n), .MOSI(MOSI), .SS_n(SS_n), .MISO(miso_a), .frame_err(ferr_a)
    );
    spi_mem_slave #(.ADDR_W(8), .DATA_W(8), .MEM_DEPTH(200)) dut_b (
        .clk(clk), .rst_n(rst_n), .MOSI(MOSI), .SS_n(SS_n), .MISO(miso_b), .frame_err(ferr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: per-instance memory and address registers.
    int         depth [2] = '{256, 200};
    logic [7:0] mem_m [2][256];
    logic [7:0] wa [2];
    logic [7:0] ra [2];

    function automatic logic [7:0] rd_model(input int k);
        return (int'(ra[k]) < depth[k]) ? mem_m[k][ra[k]] : 8'h00;
    endfunction

    function automatic logic [7:0] inc_model(input int k, input logic [7:0] a);
        return (int'(a) >= depth[k] - 1) ? 8'h00 : a + 8'h01;
    endfunction

    task automatic apply_model(input logic [1:0] cmd, input logic [7:0] pay);
        for (int k = 0; k < 2; k++) begin
            case (cmd)
                2'b00: wa[k] = pay;
                2'b01: begin
                    if (int'(wa[k]) < depth[k]) mem_m[k][wa[k]] = pay;
`ifdef SPI_MEM_AUTOINC_EN
                    wa[k] = inc_model(k, wa[k]);
`endif
                end
                2'b10: ra[k] = pay;
                default: begin
`ifdef SPI_MEM_AUTOINC_EN
                    ra[k] = inc_model(k, ra[k]);
`endif
                end
            endcase
        end
    endtask

    // Expectations for the outputs after the next rising edge.
    logic       exp_armed = 1'b0;
    logic       exp_miso_a, exp_miso_b, exp_ferr, exp_cap;
    logic [7:0] got_a, got_b;
    int         ferr_pulses = 0;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (exp_armed) begin
                check("miso_a", miso_a, exp_miso_a);
                check("miso_b", miso_b, exp_miso_b);
                check("frame_err_a", ferr_a, exp_ferr);
                check("frame_err_b", ferr_b, exp_ferr);
                if (ferr_a) ferr_pulses++;
                if (exp_cap) begin
                    got_a = {got_a[6:0], miso_a};
                    got_b = {got_b[6:0], miso_b};
                end
            end
        end
    end

    task automatic set_idle_exp();
        exp_miso_a = 1'b0;
        exp_miso_b = 1'b0;
        exp_ferr   = 1'b0;
        exp_cap    = 1'b0;
        exp_armed  = 1'b1;
    endtask

    // abort_at: step index at which SS_n is raised (or reset pulled if rst_abort); -1 for a full frame.
    task automatic frame(input logic [1:0] cmd, input logic [7:0] pay, input int abort_at, input bit rst_abort);
        int         len;
        bit         is_rd;
        bit         aborted;
        logic [7:0] da, db;
        logic [9:0] bits;
        int         tb_i;
        is_rd   = (cmd == 2'b11);
        len     = is_rd ? 3 + W + 8 + 1 : 3 + W;
        da      = rd_model(0);
        db      = rd_model(1);
        bits    = {cmd, pay};
        aborted = 1'b0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (i == abort_at) begin
                aborted = 1'b1;
                break;
            end
            SS_n = 1'b0;
            MOSI = (i >= 1 && i <= 2 + W) ? bits[W+2-i] : 1'($urandom_range(0, 1));
            set_idle_exp();
            if (is_rd && i >= 3 + W && i < 3 + W + 8) begin
                tb_i       = 7 - (i - 3 - W);
                exp_miso_a = da[tb_i];
                exp_miso_b = db[tb_i];
                exp_cap    = 1'b1;
            end
        end
        if (aborted && rst_abort) begin
            exp_armed = 1'b0;
            rst_n = 1'b0;
            SS_n  = 1'b1;
            #1;
            check("rst_async_miso_a", miso_a, 1'b0);
            check("rst_async_miso_b", miso_b, 1'b0);
            check("rst_async_ferr_a", ferr_a, 1'b0);
            for (int k = 0; k < 2; k++) begin
                wa[k] = 8'h00;
                ra[k] = 8'h00;
            end
            @(negedge clk);
            rst_n = 1'b1;
            set_idle_exp();
        end else if (aborted) begin
            SS_n = 1'b1;
            set_idle_exp();
            exp_ferr = 1'b1;
        end else begin
            @(negedge clk);
            SS_n = 1'b1;
            set_idle_exp();
            apply_model(cmd, pay);
        end
        @(negedge clk);
        SS_n = 1'b1;
        set_idle_exp();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int         pulses0;
        logic [1:0] rc;
        logic [7:0] rp;
        int         ab;

        rst_n = 1'b0;
        SS_n  = 1'b1;
        MOSI  = 1'b0;
        #1;
        check("reset_miso_a", miso_a, 1'b0);
        check("reset_ferr_a", ferr_a, 1'b0);
        check("reset_miso_b", miso_b, 1'b0);
        check("reset_ferr_b", ferr_b, 1'b0);
        for (int k = 0; k < 2; k++) begin
            wa[k] = 8'h00;
            ra[k] = 8'h00;
        end
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        set_idle_exp();
        repeat (4) @(negedge clk);

        // Fill every address so all later reads are defined.
        for (int a = 0; a < 256; a++) begin
            frame(2'b00, 8'(a), -1, 1'b0);
            frame(2'b01, 8'($urandom), -1, 1'b0);
        end

        // Basic write then read.
        frame(2'b00, 8'h3C, -1, 1'b0);
        frame(2'b01, 8'hA5, -1, 1'b0);
        frame(2'b10, 8'h3C, -1, 1'b0);
        frame(2'b11, 8'h00, -1, 1'b0);
        check("read_3c_a", got_a, 8'hA5);
        check("read_3c_b", got_b, 8'hA5);

        // Abort a write after 5 payload bits.
        pulses0 = ferr_pulses;
        frame(2'b00, 8'h3C, -1, 1'b0);
        frame(2'b01, 8'h77, 3 + 5, 1'b0);
        check("abort_pulse_count", ferr_pulses - pulses0, 1);
        frame(2'b10, 8'h3C, -1, 1'b0);
        frame(2'b11, 8'h00, -1, 1'b0);
        check("abort_no_write", got_a, 8'hA5);

        // Address wrap with two consecutive data writes.
        frame(2'b00, 8'hFF, -1, 1'b0);
        frame(2'b01, 8'h11, -1, 1'b0);
        frame(2'b01, 8'h22, -1, 1'b0);
        frame(2'b10, 8'hFF, -1, 1'b0);
        frame(2'b11, 8'h00, -1, 1'b0);
`ifdef SPI_MEM_AUTOINC_EN
        check("autoinc_ff", got_a, 8'h11);
        frame(2'b10, 8'h00, -1, 1'b0);
        frame(2'b11, 8'h00, -1, 1'b0);
        check("autoinc_wrap_00", got_a, 8'h22);
`else
        check("noinc_ff", got_a, 8'h22);
`endif

        // Out-of-range address on the depth-200 instance.
        frame(2'b00, 8'hD0, -1, 1'b0);
        frame(2'b01, 8'h55, -1, 1'b0);
        frame(2'b10, 8'hD0, -1, 1'b0);
        frame(2'b11, 8'h00, -1, 1'b0);
        check("oor_read_b", got_b, 8'h00);
        check("inrange_read_a", got_a, 8'h55);

        // Reset in the middle of TX, then read with rd_addr back at zero.
        frame(2'b00, 8'h00, -1, 1'b0);
        frame(2'b01, 8'h5A, -1, 1'b0);
        frame(2'b00, 8'h10, -1, 1'b0);
        frame(2'b01, 8'hFF, -1, 1'b0);
        frame(2'b10, 8'h10, -1, 1'b0);
        frame(2'b11, 8'h00, 3 + W + 3, 1'b1);
        frame(2'b11, 8'h00, -1, 1'b0);
        check("post_rst_read_a", got_a, 8'h5A);
        check("post_rst_read_b", got_b, 8'h5A);

        // Random frames, some aborted anywhere inside the frame.
        for (int n = 0; n < 250; n++) begin
            rc = 2'($urandom_range(0, 3));
            rp = 8'($urandom);
            ab = -1;
            if ($urandom_range(0, 5) == 0) begin
                ab = $urandom_range(1, (rc == 2'b11) ? 3 + W + 8 : 3 + W - 1);
            end
            frame(rc, rp, ab, 1'b0);
        end

        repeat (3) @(negedge clk);
        exp_armed = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
